spm_controller: RTL and testbench
=================================

# spm_controller

Sequencer for the serial-parallel multiplier datapath built from the CSA cell chain.
- Accepts unsigned N-bit operands through a start/busy/done handshake and clears the serial array.
- Presents the multiplicand in parallel, streams the multiplier LSB-first, then streams N zero bits to flush the carries.
- Deserialises the 2N-bit product and publishes it with a one-cycle done pulse.
- Sits between the bus-side register interface and the multiplier array.

## Interface
Parameters:
- N, 8, operand width in bits (N ≥ 2).
- L, 1, datapath latency in cycles from driving a dp_x bit to the matching dp_s bit (L ≥ 1).

Ports:
- clk  in  1  global clock; all logic on rising edge.
- rst  in  1  global reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  N  multiplicand; captured when start is accepted.
- b  in  N  multiplier; captured when start is accepted.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; p is valid from this cycle.
- p  out  2N  product a*b, unsigned.
- dp_clr  out  1  synchronous clear to every flip-flop in the serial array.
- dp_y  out  N  parallel multiplicand to the array; holds the captured a.
- dp_x  out  1  serial multiplier bit to the array.
- dp_s  in  1  serial product bit from the array, LSB first.

## Operation
- State machine: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - When start=1, capture a into the a_reg register and b into the b_sh shift register, then go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR: one cycle. dp_clr=1, dp_x=0. Zero the cycle counter k and the capture shift register, then go to RUN.
- RUN: lasts 2N+L cycles, k = 0 .. 2N+L-1.
  - dp_x = b_reg[k] for k < N, else 0. Implement as a right shift of b_sh.
  - For k ≥ L, capture dp_s: the capture register shifts right and dp_s enters at bit 2N-1. After 2N captures, bit 0 holds the product LSB.
  - At k = 2N+L-1, load p from the final capture value (including that cycle's dp_s), then go to DONE.
- DONE: one cycle. done=1. Return to IDLE.
- dp_y always drives a_reg. a_reg changes only when start is accepted.
- p changes only on the RUN→DONE transition. It holds its value through subsequent operations until the next result is loaded.
- start outside IDLE is ignored and not queued. This includes the DONE cycle.
- Counter width: clog2(2N+L+1) bits.
- No overflow is possible: a*b < 2^(2N).

## Timing
- Reset values: state=IDLE, busy=0, done=0, p=0, dp_clr=1 during the reset cycle then 0 in IDLE, dp_x=0, dp_y=0. All internal registers are 0.
- Start sampled at edge T:
  - busy=1 from T+1.
  - CLEAR occupies cycle T+1.
  - RUN occupies T+2 .. T+2N+L+1.
  - done=1 in cycle T+2N+L+2.
  - busy=0 and a new start can be accepted from T+2N+L+3.
- Total latency, start to done: 2N+L+2 cycles. Throughput: one product per 2N+L+3 cycles.
- Reset mid-operation (any state) returns to IDLE on the next edge and clears p. No done pulse is produced. dp_clr=1 in that cycle.
- start held high continuously restarts immediately after each DONE. There is exactly one idle cycle between done and the next CLEAR.
- a and b may change freely after acceptance without affecting the operation in flight.

## Test plan
- Reset: assert rst for 2 cycles in any state → busy=0, done=0, p=0, dp_x=0. dp_clr=1 while rst=1.
- Basic, N=8, L=1, behavioural array model: a=13, b=11, start → done exactly 19 cycles after start acceptance, p=143. dp_x sequence is 1,1,0,1,0,0,0,0 then 8 zeros.
- Corners: a=255,b=255 → p=65025; a=0,b=200 → p=0; a=1,b=128 → p=128; a=128,b=128 → p=16384.
- Ignored start: pulse start at RUN k=3 and again during DONE, with different a/b → exactly one done, p equals the first product, a_reg unchanged.
- Reset mid-run: a=200,b=100, assert rst at RUN k=5 → IDLE next cycle, no done, p=0. Then a=7,b=9 → p=63.
- Back-to-back with start held high, random operands over 1000 operations → each p matches the reference model. done spacing is 2N+L+3 cycles. p is stable between done pulses.

Source files
------------

// File: rtl/spm_controller.sv
// spm_controller: sequencer for the serial-parallel multiplier array.
// Captures unsigned operands on start, clears the serial array, presents the
// multiplicand in parallel, streams the multiplier LSB-first followed by N
// zero bits to flush the carries, then deserialises the 2N-bit product.
//
// Handshake: start is sampled only in IDLE. When it is accepted, busy rises
// on the next cycle and stays high until the state returns to IDLE. done is a
// one-cycle pulse in the DONE state, and p is valid from that cycle. p holds
// its value until the next result is loaded. A start seen outside IDLE
// (including the DONE cycle) is dropped and is not queued.
module spm_controller #(
    parameter int N = 8,
    parameter int L = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p,
    output logic           dp_clr,
    output logic [N-1:0]   dp_y,
    output logic           dp_x,
    input  logic           dp_s,
    output logic [1:0]     dbg_state
);

    localparam int KW = $clog2(2*N + L + 1);
    // k value on the last RUN cycle
    localparam logic [KW-1:0] K_LAST = KW'(2*N + L - 1);
    // first k at which dp_s carries a valid product bit
    localparam logic [KW-1:0] K_CAP  = KW'(L);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [KW-1:0]  k_q, k_d;
    logic [2*N-1:0] cap_q, cap_d;
    logic [2*N-1:0] p_q, p_d;
    logic [2*N-1:0] cap_shift;

    // Capture register after taking this cycle's dp_s at the top end.
    assign cap_shift = {dp_s, cap_q[2*N-1:1]};

    // State and datapath registers; reset clears everything, including p.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_sh_q  <= '0;
            k_q     <= '0;
            cap_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_sh_q  <= b_sh_d;
            k_q     <= k_d;
            cap_q   <= cap_d;
            p_q     <= p_d;
        end
    end

    // Next-state logic and array control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_sh_d  = b_sh_q;
        k_d     = k_q;
        cap_d   = cap_q;
        p_d     = p_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        dp_clr  = rst;
        dp_x    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_sh_d  = b;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dp_clr  = 1'b1;
                k_d     = '0;
                cap_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Zeros shift in behind the multiplier, so after N cycles
                // dp_x naturally becomes the flush stream.
                dp_x   = b_sh_q[0] & ~rst;
                b_sh_d = b_sh_q >> 1;
                k_d    = k_q + KW'(1);
                if (k_q >= K_CAP) begin
                    cap_d = cap_shift;
                end
                if (k_q == K_LAST) begin
                    p_d     = cap_shift;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign p         = p_q;
    assign dp_y      = a_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spm_controller.sv
// tb_spm_controller: random and directed operations against a behavioural
// serial array and a queue of expected products (plain a*b).
module tb_spm_controller;

    localparam int N       = 8;
    localparam int L       = 1;
    localparam int RUN_LEN = 2*N + L;
    localparam int PERIOD  = 2*N + L + 3;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;
    logic           dp_clr;
    logic [N-1:0]   dp_y;
    logic           dp_x;
    logic           dp_s;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] exp_q[$];
    bit b2b = 1'b0;
    int cyc = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    spm_controller #(.N(N), .L(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .p         (p),
        .dp_clr    (dp_clr),
        .dp_y      (dp_y),
        .dp_x      (dp_x),
        .dp_s      (dp_s),
        .dbg_state (dbg_state)
    );

    // ---------------- behavioural serial array ----------------
    // Accumulates dp_y * 2^i for every incoming multiplier bit i; bit i of the
    // running sum is final once bit i has been added, and leaves after L cycles.
    logic [63:0] acc = '0;
    logic [63:0] acc_nxt;
    logic [5:0]  idx = '0;
    logic [L:0]  pipe = '0;

    assign acc_nxt = acc + (dp_x ? (64'(dp_y) << idx) : 64'd0);
    assign dp_s    = pipe[L-1];

    always @(posedge clk) begin
        if (dp_clr) begin
            acc  <= '0;
            idx  <= '0;
            pipe <= '0;
        end else begin
            acc  <= acc_nxt;
            pipe <= {pipe[L-1:0], acc_nxt[idx]};
            if (idx != 6'd63) idx <= idx + 6'd1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected product on every done pulse, checks done
    // spacing in back-to-back mode and that p holds between results.
    initial begin
        logic [2*N-1:0] last_p;
        logic [2*N-1:0] e;
        int  last_done;
        bit  prev_b2b;
        last_p    = '0;
        last_done = -1;
        prev_b2b  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_p   = '0;
                prev_b2b = 1'b0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_without_request", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", p, e);
                end
                if (b2b && prev_b2b) check("done_spacing", cyc - last_done, PERIOD);
                prev_b2b  = b2b;
                last_done = cyc;
                last_p    = p;
            end else begin
                check("p_stable", p, last_p);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered at a negedge with the DUT idle; start is accepted at the next edge.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input bit hold, input bit inject);
        logic [RUN_LEN-1:0] xs;
        logic [RUN_LEN-1:0] xexp;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        exp_q.push_back((2*N)'(ta) * (2*N)'(tb_v));
        @(negedge clk);                       // CLEAR cycle
        start = hold;
        a     = N'($urandom);
        b     = N'($urandom);
        check("busy_clear", busy, 1);
        check("dp_clr_clear", dp_clr, 1);
        check("dp_x_clear", dp_x, 0);
        for (int k = 0; k < RUN_LEN; k++) begin
            @(negedge clk);                   // RUN k
            xs[k]   = dp_x;
            xexp[k] = (k < N) ? tb_v[k] : 1'b0;
            check("done_in_run", done, 0);
            if (inject && k == 3) begin
                start = 1'b1;
                a     = ~ta;
                b     = ~tb_v;
            end
            if (inject && k == 4) start = hold;
        end
        check("dp_x_seq", xs, xexp);
        @(negedge clk);                       // DONE cycle
        check("done_pulse", done, 1);
        check("dp_y_hold", dp_y, ta);
        if (inject) begin
            start = 1'b1;
            a     = N'($urandom);
            b     = N'($urandom);
        end
        @(negedge clk);                       // IDLE cycle
        check("busy_idle", busy, 0);
        check("done_idle", done, 0);
        check("dp_y_idle", dp_y, ta);
        if (!hold) start = 1'b0;
    endtask

    // Starts an operation and asserts rst for two cycles at RUN k = kab.
    task automatic run_abort(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input int kab);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);                       // CLEAR cycle
        start = 1'b0;
        for (int k = 0; k <= kab; k++) @(negedge clk);
        rst = 1'b1;                           // during RUN k = kab
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_p", p, 0);
        check("abort_dp_clr", dp_clr, 1);
        check("abort_dp_x", dp_x, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_clr", dp_clr, 0);
        check("abort_idle_p", p, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        check("rst_dp_clr", dp_clr, 1);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_p", p, 0);
        check("rst_dp_x", dp_x, 0);
        check("rst_dp_clr2", dp_clr, 1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_dp_clr", dp_clr, 0);
        check("idle_dp_y", dp_y, 0);
        check("idle_busy", busy, 0);

        run_op(8'd13,  8'd11,  1'b0, 1'b0);
        run_op(8'd255, 8'd255, 1'b0, 1'b0);
        run_op(8'd0,   8'd200, 1'b0, 1'b0);
        run_op(8'd1,   8'd128, 1'b0, 1'b0);
        run_op(8'd128, 8'd128, 1'b0, 1'b0);
        run_op(8'd5,   8'd6,   1'b0, 1'b1);
        run_abort(8'd200, 8'd100, 5);
        run_op(8'd7,   8'd9,   1'b0, 1'b0);

        b2b = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = N'($urandom_range(0, (1 << N) - 1));
            run_op(ra, rb, 1'b1, 1'b0);
        end
        start = 1'b0;
        b2b   = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
